// File: rtl/clint_pkg.sv
// Shared constants and types for the core-local interrupt controller.
// Holds instruction encodings, cause values, CSR addresses and state encodings.
// Also provides the mstatus bit-edit helpers used on trap entry and return.
package clint_pkg;

    localparam int          INT_BUS_W    = 8;

    localparam logic        RST_ENABLE   = 1'b0;
    localparam logic        WRITE_ENABLE = 1'b1;
    localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;

    localparam logic [31:0] INST_ECALL   = 32'h0000_0073;
    localparam logic [31:0] INST_EBREAK  = 32'h0010_0073;
    localparam logic [31:0] INST_MRET    = 32'h3020_0073;

    localparam logic [31:0] CAUSE_ECALL  = 32'd11;
    localparam logic [31:0] CAUSE_EBREAK = 32'd3;
    localparam logic [31:0] INT_CAUSE    = 32'h8000_0004;

    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MEPC,
        S_MSTATUS,
        S_MCAUSE,
        S_MSTATUS_MRET
    } csr_state_t;

    // Trap entry: MPIE takes the old MIE, MIE is cleared.
    function automatic logic [31:0] trap_mstatus(input logic [31:0] m);
        return {m[31:8], m[3], m[6:4], 1'b0, m[2:0]};
    endfunction

    // Return: MIE takes MPIE, MPIE is set.
    function automatic logic [31:0] mret_mstatus(input logic [31:0] m);
        return {m[31:8], 1'b1, m[6:4], m[7], m[2:0]};
    endfunction

endpackage

// File: rtl/clint_if.sv
// Second CSR port between the interrupt controller and the CSR file.
// Carries the write bus out and the live mtvec/mepc/mstatus/MIE values back.
// The master drives writes; the slave (CSR file) drives the live values.
interface clint_csr_if;
    logic        we;
    logic [31:0] waddr;
    logic [31:0] raddr;
    logic [31:0] data;
    logic [31:0] mtvec;
    logic [31:0] mepc;
    logic [31:0] mstatus;
    logic        global_int_en;

    modport master (
        output we, waddr, raddr, data,
        input  mtvec, mepc, mstatus, global_int_en
    );

    modport slave (
        input  we, waddr, raddr, data,
        output mtvec, mepc, mstatus, global_int_en
    );
endinterface

// File: rtl/clint.sv
// Trap sequencer: detects MRET/ECALL/EBREAK/interrupts, writes mepc/mstatus/mcause.
// Latency: trap entry 4 cycles (redirect at T+3), return 2 cycles (redirect at T+1).
// Stalls the pipeline via hold_flag_o from the detect cycle until the redirect.
module clint
    import clint_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [INT_BUS_W-1:0] int_flag_i,
    input  logic [31:0]          inst_i,
    input  logic [31:0]          inst_addr_i,
    input  logic                 jump_flag_i,
    input  logic [31:0]          jump_addr_i,
    input  logic                 div_started_i,
    clint_csr_if.master          csr_bus,
    output logic                 hold_flag_o,
    output logic                 int_assert_o,
    output logic [31:0]          int_addr_o
);

    csr_state_t  state_q, state_d;
    logic [31:0] cause_q, cause_d;
    logic [31:0] epc_q,   epc_d;

    logic        is_mret, is_ecall, is_ebreak, is_async;
    logic        we;
    logic [31:0] waddr, wdata;

    assign is_mret   = (inst_i == INST_MRET);
    assign is_ecall  = (inst_i == INST_ECALL);
    assign is_ebreak = (inst_i == INST_EBREAK);
    assign is_async  = (|int_flag_i) && csr_bus.global_int_en && !div_started_i;

    // Event detection in IDLE, next-state selection and output decode of the current state.
    always_comb begin
        state_d      = state_q;
        cause_d      = cause_q;
        epc_d        = epc_q;
        we           = 1'b0;
        waddr        = ZERO_WORD;
        wdata        = ZERO_WORD;
        hold_flag_o  = 1'b0;
        int_assert_o = 1'b0;
        int_addr_o   = ZERO_WORD;
        unique case (state_q)
            S_IDLE: begin
                if (is_mret) begin
                    hold_flag_o = 1'b1;
                    state_d     = S_MSTATUS_MRET;
                end else if (is_ecall || is_ebreak) begin
                    hold_flag_o = 1'b1;
                    state_d     = S_MEPC;
                    cause_d     = is_ecall ? CAUSE_ECALL : CAUSE_EBREAK;
                    epc_d       = inst_addr_i;
                end else if (is_async) begin
                    // A redirect in flight means the interrupted instruction is the jump target.
                    hold_flag_o = 1'b1;
                    state_d     = S_MEPC;
                    cause_d     = INT_CAUSE;
                    epc_d       = jump_flag_i ? jump_addr_i : inst_addr_i;
                end
            end
            S_MEPC: begin
                hold_flag_o = 1'b1;
                we          = WRITE_ENABLE;
                waddr       = {20'h0, CSR_MEPC};
                wdata       = epc_q;
                state_d     = S_MSTATUS;
            end
            S_MSTATUS: begin
                hold_flag_o = 1'b1;
                we          = WRITE_ENABLE;
                waddr       = {20'h0, CSR_MSTATUS};
                wdata       = trap_mstatus(csr_bus.mstatus);
                state_d     = S_MCAUSE;
            end
            S_MCAUSE: begin
                hold_flag_o  = 1'b1;
                we           = WRITE_ENABLE;
                waddr        = {20'h0, CSR_MCAUSE};
                wdata        = cause_q;
                int_assert_o = 1'b1;
                int_addr_o   = csr_bus.mtvec;
                state_d      = S_IDLE;
            end
            S_MSTATUS_MRET: begin
                hold_flag_o  = 1'b1;
                we           = WRITE_ENABLE;
                waddr        = {20'h0, CSR_MSTATUS};
                wdata        = mret_mstatus(csr_bus.mstatus);
                int_assert_o = 1'b1;
                int_addr_o   = csr_bus.mepc;
                state_d      = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign csr_bus.we    = we;
    assign csr_bus.waddr = waddr;
    assign csr_bus.data  = wdata;
    assign csr_bus.raddr = ZERO_WORD;

    // State, latched cause and return PC; synchronous reset back to IDLE.
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            state_q <= S_IDLE;
            cause_q <= ZERO_WORD;
            epc_q   <= ZERO_WORD;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            epc_q   <= epc_d;
        end
    end

endmodule

// File: tb/tb_clint.sv
// Testbench for clint: directed trap/return scenarios followed by random traffic.
// A cycle-level reference model pushes expected CSR writes and hold values into queues.
// A monitor on the falling edge pops and compares against the DUT outputs.
module tb_clint;

    localparam logic [31:0] ECALL  = 32'h0000_0073;
    localparam logic [31:0] EBREAK = 32'h0010_0073;
    localparam logic [31:0] MRET   = 32'h3020_0073;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    typedef struct {
        int          cyc;
        logic        we;
        logic [31:0] waddr;
        logic [31:0] data;
        logic        ia;
        logic [31:0] iaddr;
    } exp_t;

    typedef struct {
        int   cyc;
        logic hold;
    } hexp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  int_flag;
    logic [31:0] inst, inst_addr, jump_addr, mtvec_r;
    logic        jump_flag, div_started;
    logic        hold, ia;
    logic [31:0] iaddr;

    logic        ex_we;
    logic [11:0] ex_addr;
    logic [31:0] ex_dat;
    logic [31:0] mstatus_r, mepc_r;

    int          cyc = 0;
    int          busy = 0;
    int          errors = 0;
    int          checks = 0;
    exp_t        q[$];
    hexp_t       hq[$];

    clint_csr_if bus();

    assign bus.mtvec         = mtvec_r;
    assign bus.mepc          = mepc_r;
    assign bus.mstatus       = mstatus_r;
    assign bus.global_int_en = mstatus_r[3];

    clint dut (
        .clk          (clk),
        .rst          (rst),
        .int_flag_i   (int_flag),
        .inst_i       (inst),
        .inst_addr_i  (inst_addr),
        .jump_flag_i  (jump_flag),
        .jump_addr_i  (jump_addr),
        .div_started_i(div_started),
        .csr_bus      (bus),
        .hold_flag_o  (hold),
        .int_assert_o (ia),
        .int_addr_o   (iaddr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Minimal CSR file: ex writes win, resets with the same rst.
    always_ff @(posedge clk) begin
        if (!rst) begin
            mstatus_r <= 32'h0;
            mepc_r    <= 32'h0;
        end else if (ex_we) begin
            if (ex_addr == 12'h300) mstatus_r <= ex_dat;
            if (ex_addr == 12'h341) mepc_r    <= ex_dat;
        end else if (bus.we) begin
            if (bus.waddr[11:0] == 12'h300) mstatus_r <= bus.data;
            if (bus.waddr[11:0] == 12'h341) mepc_r    <= bus.data;
        end
    end

    // Reference model: decides from the rules what happens in this cycle and the next few.
    always @(posedge clk) begin
        int          c;
        logic        m_mret, m_sync, m_async, ev;
        logic [31:0] ms, pc, cause;
        #2;
        c       = cyc;
        m_mret  = (inst == MRET);
        m_sync  = (inst == ECALL) || (inst == EBREAK);
        m_async = (int_flag != 8'h0) && mstatus_r[3] && !div_started;
        ev      = (busy == 0) && (m_mret || m_sync || m_async);
        hq.push_back('{c, (busy != 0) || ev});
        if (!rst) begin
            while (q.size() > 0 && q[$].cyc > c) void'(q.pop_back());
            busy = 0;
        end else if (ev) begin
            if (m_mret) begin
                ms    = mstatus_r;
                ms[3] = mstatus_r[7];
                ms[7] = 1'b1;
                q.push_back('{c + 1, 1'b1, 32'h300, ms, 1'b1, mepc_r});
                busy = 1;
            end else begin
                pc    = m_sync ? inst_addr : (jump_flag ? jump_addr : inst_addr);
                cause = m_sync ? ((inst == ECALL) ? 32'd11 : 32'd3) : 32'h8000_0004;
                ms    = mstatus_r;
                ms[7] = mstatus_r[3];
                ms[3] = 1'b0;
                q.push_back('{c + 1, 1'b1, 32'h341, pc,    1'b0, 32'h0});
                q.push_back('{c + 2, 1'b1, 32'h300, ms,    1'b0, 32'h0});
                q.push_back('{c + 3, 1'b1, 32'h342, cause, 1'b1, mtvec_r});
                busy = 3;
            end
        end else if (busy > 0) begin
            busy = busy - 1;
        end
    end

    // Monitor: compares DUT outputs against whatever the model expects for this cycle.
    always @(negedge clk) begin
        int    c;
        exp_t  e;
        hexp_t h;
        c = cyc;
        if (hq.size() > 0) begin
            h = hq.pop_front();
            checks++;
            if (h.cyc != c || hold !== h.hold) begin
                errors++;
                $display("FAIL hold cyc=%0d got=%b exp=%b (model cyc %0d)", c, hold, h.hold, h.cyc);
            end
        end
        while (q.size() > 0 && q[0].cyc < c) begin
            e = q.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_write cyc=%0d got=none exp addr=%h data=%h", e.cyc, e.waddr, e.data);
        end
        if (q.size() > 0 && q[0].cyc == c) begin
            e = q.pop_front();
            checks++;
            if (bus.we !== e.we || bus.waddr !== e.waddr || bus.data !== e.data ||
                ia !== e.ia || iaddr !== e.iaddr) begin
                errors++;
                $display("FAIL csr_write cyc=%0d got we=%b addr=%h data=%h ia=%b iaddr=%h exp we=%b addr=%h data=%h ia=%b iaddr=%h",
                         c, bus.we, bus.waddr, bus.data, ia, iaddr, e.we, e.waddr, e.data, e.ia, e.iaddr);
            end
        end else begin
            checks++;
            if (bus.we !== 1'b0 || bus.waddr !== 32'h0 || bus.data !== 32'h0 ||
                ia !== 1'b0 || iaddr !== 32'h0) begin
                errors++;
                $display("FAIL quiet cyc=%0d got we=%b addr=%h data=%h ia=%b iaddr=%h exp all zero",
                         c, bus.we, bus.waddr, bus.data, ia, iaddr);
            end
        end
        checks++;
        if (bus.raddr !== 32'h0) begin
            errors++;
            $display("FAIL raddr cyc=%0d got=%h exp=0", c, bus.raddr);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One cycle of an ex-side CSR write with no competing event.
    task automatic ex_write(input logic [11:0] a, input logic [31:0] d);
        inst     = NOP;
        int_flag = 8'h0;
        ex_we    = 1'b1;
        ex_addr  = a;
        ex_dat   = d;
        step();
        ex_we    = 1'b0;
    endtask

    initial begin
        logic [31:0] r;
        rst = 1'b0; int_flag = 8'h0; inst = NOP; inst_addr = 32'h0;
        jump_flag = 1'b0; jump_addr = 32'h0; div_started = 1'b0; mtvec_r = 32'h200;
        ex_we = 1'b0; ex_addr = 12'h0; ex_dat = 32'h0;
        repeat (3) step();
        rst = 1'b1;
        step();

        // ECALL at 0x100, mstatus=0x8, mtvec=0x200; instruction held through the stall.
        ex_write(12'h300, 32'h8);
        inst_addr = 32'h100; inst = ECALL;
        repeat (4) step();
        inst = NOP;
        repeat (3) step();

        // Interrupt during a redirect: return PC is the jump target.
        ex_write(12'h300, 32'h8);
        int_flag = 8'h01; jump_flag = 1'b1; jump_addr = 32'h340; inst_addr = 32'h500;
        repeat (4) step();
        int_flag = 8'h0; jump_flag = 1'b0;
        repeat (2) step();

        // MRET with mstatus=0x80, mepc=0x104.
        ex_write(12'h300, 32'h80);
        ex_write(12'h341, 32'h104);
        inst = MRET;
        step();
        inst = NOP;
        repeat (3) step();

        // Masked by MIE, then deferred by an in-flight divide.
        ex_write(12'h300, 32'h0);
        int_flag = 8'h10;
        repeat (4) step();
        ex_write(12'h300, 32'h8);
        int_flag = 8'h10; div_started = 1'b1;
        repeat (4) step();
        div_started = 1'b0;
        repeat (4) step();
        int_flag = 8'h0;
        repeat (2) step();

        // ECALL and interrupt together: ECALL first, interrupt after MRET restores MIE.
        ex_write(12'h300, 32'h8);
        inst_addr = 32'h600; inst = ECALL; int_flag = 8'h80;
        step();
        inst = NOP;
        repeat (6) step();
        inst = MRET;
        step();
        inst = NOP;
        repeat (8) step();
        int_flag = 8'h0;
        repeat (2) step();

        // Reset two cycles into a trap sequence.
        ex_write(12'h300, 32'h8);
        inst_addr = 32'h700; inst = EBREAK;
        step();
        inst = NOP;
        step();
        rst = 1'b0;
        step();
        rst = 1'b1;
        repeat (4) step();

        // Random traffic.
        for (int i = 0; i < 2000; i++) begin
            if (busy == 0 && $urandom_range(0, 9) == 0) begin
                mtvec_r = $urandom & 32'hFFFF_FFFC;
                if ($urandom_range(0, 1) == 0) ex_write(12'h300, $urandom);
                else                           ex_write(12'h341, $urandom & 32'hFFFF_FFFC);
            end else begin
                case ($urandom_range(0, 19))
                    0:       inst = ECALL;
                    1:       inst = EBREAK;
                    2:       inst = MRET;
                    default: begin
                        r    = $urandom;
                        inst = {r[31:7], 7'h13};
                    end
                endcase
                if ($urandom_range(0, 3) == 0)
                    int_flag = ($urandom_range(0, 1) == 0) ? 8'h0 : 8'($urandom_range(1, 255));
                inst_addr   = $urandom & 32'hFFFF_FFFC;
                jump_addr   = $urandom & 32'hFFFF_FFFC;
                jump_flag   = ($urandom_range(0, 3) == 0);
                div_started = ($urandom_range(0, 3) == 0);
                step();
            end
        end

        inst = NOP; int_flag = 8'h0; div_started = 1'b0; jump_flag = 1'b0;
        repeat (10) step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/clint.md
# clint

Core-local interrupt controller: the trap-sequencing master on the CSR file's second write/read port. It detects synchronous exceptions (ECALL, EBREAK), asynchronous interrupts and MRET. It then stalls the pipeline and walks a fixed sequence of CSR writes (mepc, mstatus, mcause). Finally it issues a one-cycle redirect to ex/pc, to mtvec on trap entry or to mepc on return.

## Interface
- INT_CAUSE, 32'h8000_0004, mcause value written for any asynchronous interrupt
- clk  in  1  system clock
- rst  in  1  synchronous, active-low reset (`RstEnable` = 1'b0)
- int_flag_i  in  8  external interrupt request lines; any nonzero bit = request (level)
- inst_i  in  32  instruction currently in decode/execute
- inst_addr_i  in  32  PC of inst_i
- jump_flag_i  in  1  ex is redirecting this cycle
- jump_addr_i  in  32  ex redirect target
- div_started_i  in  1  multi-cycle divide in flight; blocks async interrupt entry
- csr_mtvec_i, csr_mepc_i, csr_mstatus_i  in  32 each  live CSR values from csr
- global_int_en_i  in  1  mstatus.MIE from csr
- we_o  out  1  CSR write enable to csr
- waddr_o  out  32  CSR write address (bits [11:0] significant)
- raddr_o  out  32  CSR read address; tied to `ZeroWord`
- data_o  out  32  CSR write data
- hold_flag_o  out  1  pipeline stall request
- int_assert_o  out  1  one-cycle redirect strobe
- int_addr_o  out  32  redirect target, valid while int_assert_o=1

## Operation
- Event detect runs only in IDLE, with priority MRET > sync > async:
  - MRET: inst_i == 32'h3020_0073.
  - sync: inst_i == 32'h0000_0073 (ECALL, cause 11) or 32'h0010_0073 (EBREAK, cause 3).
  - async: int_flag_i != 0 && global_int_en_i && !div_started_i (cause INT_CAUSE).
- On detect, the block latches the cause and the return PC:
  - sync: inst_addr_i.
  - async: jump_addr_i if jump_flag_i, else inst_addr_i.
- State register csr_state: IDLE, MEPC, MSTATUS, MCAUSE, MSTATUS_MRET. Outputs decode combinationally from csr_state; transitions happen on clk.
- Trap path IDLE→MEPC→MSTATUS→MCAUSE→IDLE:
  - MEPC: write mepc = latched PC.
  - MSTATUS: write mstatus with MPIE(bit7) = MIE(bit3), MIE = 0, other bits unchanged.
  - MCAUSE: write mcause = latched cause; int_assert_o=1, int_addr_o=csr_mtvec_i.
- Return path IDLE→MSTATUS_MRET→IDLE:
  - MSTATUS_MRET: write mstatus with MIE = MPIE, MPIE = 1; int_assert_o=1, int_addr_o=csr_mepc_i.
- Any event seen outside IDLE is ignored. int_flag_i is level, so it is re-sampled after return.
- Synchronous ECALL and interrupt in the same cycle: ECALL taken. The interrupt stays pending and is taken after the handler re-enables MIE.
- Outside the states that write, we_o=0, waddr_o=0, data_o=0. The csr file gives ex writes priority; hold_flag_o guarantees ex issues none during a sequence.

## Timing
- Reset (rst=0 at clk edge): csr_state=IDLE, latched cause/PC=0. All outputs 0 (combinational decode of IDLE, no event).
- hold_flag_o is combinational:
  - 1 in the detect cycle T.
  - 1 in every non-IDLE cycle.
  - 1 in IDLE whenever an event is detected.
  - Otherwise 0.
- Trap: T detect, T+1 mepc write, T+2 mstatus write, T+3 mcause write + int_assert_o. IDLE at T+4. hold_flag_o high T..T+3.
- MRET: T detect, T+1 mstatus write + int_assert_o, IDLE at T+2. hold_flag_o high T..T+1.
- int_assert_o is exactly one cycle per sequence. It always coincides with the final CSR write.
- Reset mid-sequence returns to IDLE on that edge. csr resets on the same rst, so no partial state survives.
- Width rules: all data/addresses 32-bit. mstatus bit edits only touch bits 3 and 7.

## Structure
- defines.v holds:
  - instruction constants INST_ECALL, INST_EBREAK, INST_MRET;
  - csr_state encodings;
  - cause constants;
  - INT_BUS width (7:0).
- CSR addresses (`CSR_MEPC`, `CSR_MSTATUS`, `CSR_MCAUSE`) and `RstEnable`/`WriteEnable`/`ZeroWord` already live there.
- Single module; no sub-module is natural.

## Test plan
- ECALL at PC 0x100, mstatus=0x8, mtvec=0x200:
  - writes at T+1..T+3: mepc=0x100, mstatus=0x80, mcause=11.
  - int_assert_o at T+3 with addr 0x200; hold T..T+3.
- int_flag_i=0x01, MIE=1, jump_flag_i=1, jump_addr_i=0x340:
  - mepc=0x340, mcause=0x8000_0004.
- MRET with mstatus=0x80, mepc=0x104:
  - T+1 write mstatus=0x88.
  - int_assert_o with addr 0x104; hold T..T+1.
- Interrupt masked:
  - MIE=0 → no hold, no writes.
  - MIE=1 with div_started_i=1 → deferred until div_started_i drops.
- ECALL and int_flag_i same cycle:
  - mcause=11.
  - After MRET restores MIE=1, interrupt taken with mcause=0x8000_0004.
- rst=0 asserted at T+2 of a trap sequence:
  - next cycle all outputs 0, IDLE; no int_assert_o.
